// File: rtl/wb_pkg.sv
// wb_pkg: opcode constants, load func3 encodings and FSM state type for the writeback stage.
package wb_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_NOP    = 7'b0010011;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, ERR} state_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-stage inputs, memory response and register-file write port; fwd_* exist only with WB_BYPASS_EN.
interface wb_stage_if;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [63:0] in_alu_result;
  logic [63:0] in_pc_plus4;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        wvalid;
  logic [4:0]  wrd;
  logic [63:0] wdata;
  logic [6:0]  wopcode;
  logic        load_err;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
`endif
  modport slave (
`ifdef WB_BYPASS_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    input  in_valid, in_opcode, in_rd, in_func3, in_alu_result, in_pc_plus4, mem_rvalid, mem_rdata,
    output stall, wvalid, wrd, wdata, wopcode, load_err
  );
  modport master (
`ifdef WB_BYPASS_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    output in_valid, in_opcode, in_rd, in_func3, in_alu_result, in_pc_plus4, mem_rvalid, mem_rdata,
    input  stall, wvalid, wrd, wdata, wopcode, load_err
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: selects the addressed lane of a read doubleword, extends it by func3, and flags misalignment.
module load_align
  import wb_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  func3,
  output logic [63:0] value,
  output logic        misaligned
);
  logic [63:0] s;
  always_comb begin
    s = rdata >> {offset, 3'b000};
    value = func3 == F3_LB  ? {{56{s[7]}}, s[7:0]} :
            func3 == F3_LH  ? {{48{s[15]}}, s[15:0]} :
            func3 == F3_LW  ? {{32{s[31]}}, s[31:0]} :
            func3 == F3_LBU ? {56'd0, s[7:0]} :
            func3 == F3_LHU ? {48'd0, s[15:0]} :
            func3 == F3_LWU ? {32'd0, s[31:0]} : s;
    misaligned = (func3[1:0] == 2'b01 && offset[0]) ||
                 (func3[1:0] == 2'b10 && |offset[1:0]) ||
                 (func3 == F3_LD && |offset);
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load wait/timeout FSM and registered register-file write port.
// Define WB_BYPASS_EN to expose fwd_valid/fwd_rd/fwd_data, the next-edge values of the write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic    clk,
  input logic    rst,
  wb_stage_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic [2:0]    f3_q, off_q, f3, off;
  logic [63:0]   ld_val, n_wdata;
  logic [4:0]    n_wrd;
  logic [6:0]    n_wop;
  logic          mis, is_load, take, accept, reject, done, tout, n_wvalid;
  // While waiting, extraction uses the latched load; in IDLE the live inputs feed the alignment check.
  assign f3  = state == WAIT_MEM ? f3_q : bus.in_func3;
  assign off = state == WAIT_MEM ? off_q : bus.in_alu_result[2:0];
  load_align u_align (
    .rdata(bus.mem_rdata),
    .offset(off),
    .func3(f3),
    .value(ld_val),
    .misaligned(mis)
  );
  always_comb begin
    is_load = bus.in_opcode == OP_LOAD;
    take = state == IDLE && bus.in_valid;
    accept = take && is_load && !mis && f3 != F3_BAD;
    reject = take && is_load && (mis || f3 == F3_BAD);
    done = state == WAIT_MEM && bus.mem_rvalid;
    tout = state == WAIT_MEM && !bus.mem_rvalid && cnt == CW'(MEM_TIMEOUT - 1);
    nstate = accept ? WAIT_MEM : (reject || tout) ? ERR : (done || state == ERR) ? IDLE : state;
    bus.stall = !rst && (accept || (state == WAIT_MEM && !bus.mem_rvalid && !tout));
    n_wvalid = take && !is_load ? !(bus.in_opcode == OP_STORE || bus.in_opcode == OP_BRANCH || bus.in_rd == 5'd0) :
               done && rd_q != 5'd0;
    n_wrd = !n_wvalid ? 5'd0 : done ? rd_q : bus.in_rd;
    n_wdata = take && !is_load ? ((bus.in_opcode == OP_JAL || bus.in_opcode == OP_JALR) ? bus.in_pc_plus4 : bus.in_alu_result) :
              done ? ld_val : 64'd0;
    n_wop = take && !is_load ? bus.in_opcode : done ? OP_LOAD : OP_NOP;
  end
`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = !rst && n_wvalid;
  assign bus.fwd_rd    = rst ? 5'd0 : n_wrd;
  assign bus.fwd_data  = rst ? 64'd0 : n_wdata;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      bus.wvalid <= 1'b0;
      bus.wrd <= '0;
      bus.wdata <= '0;
      bus.wopcode <= OP_NOP;
      bus.load_err <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= accept ? '0 : state == WAIT_MEM ? cnt + 1'b1 : cnt;
      if (accept) begin
        rd_q <= bus.in_rd;
        f3_q <= bus.in_func3;
        off_q <= bus.in_alu_result[2:0];
      end
      bus.wvalid <= n_wvalid;
      bus.wrd <= n_wrd;
      bus.wdata <= n_wdata;
      bus.wopcode <= n_wop;
      bus.load_err <= nstate == ERR;
    end
  end
endmodule
